dmem_ctrl: RTL

//  Data-memory responder for the core's load/store port: accepts read/write requests, services them from an

---
 rtl/dmem_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store data-memory responder with byte-lane writes, write-first read bypass and sticky fault capture
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren_i,
  input  logic [31:0] mem_raddr_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_rvalid_o,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_wsize_i,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d, err_addr_q, err_addr_d;
  logic [31:0] w_off, r_off, w_lane, r_word;
  logic [1:0]  err_cause_q, err_cause_d, w_cause;
  logic [3:0]  w_strb;
  logic [AW-1:0] w_idx, r_idx;
  logic rvalid_q, rvalid_d, err_q, err_d;
  logic w_bad, w_oor, w_mis, w_fault, r_fault, we;
  always_comb begin
    w_off = mem_waddr_i - BASE_ADDR;
    r_off = mem_raddr_i - BASE_ADDR;
    w_idx = w_off[AW+1:2];
    r_idx = r_off[AW+1:2];
    w_bad = mem_wsize_i == 2'b11;
    w_oor = w_off >= SPAN;
    w_mis = mem_wsize_i == 2'b01 ? mem_waddr_i[0] : mem_wsize_i == 2'b10 ? |mem_waddr_i[1:0] : 1'b0;
    w_cause = w_bad ? 2'b11 : w_oor ? 2'b10 : 2'b01;
    w_fault = mem_wen_i & (w_bad | w_oor | w_mis);
    r_fault = mem_ren_i & (r_off >= SPAN);
    we = mem_wen_i & ~w_fault & ~rst;
    w_strb = mem_wsize_i == 2'b00 ? 4'b0001 << mem_waddr_i[1:0] :
             mem_wsize_i == 2'b01 ? 4'b0011 << {mem_waddr_i[1], 1'b0} : 4'b1111;
    w_lane = mem_wsize_i == 2'b00 ? {4{mem_wdata_i[7:0]}} :
             mem_wsize_i == 2'b01 ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
    // write-first: a committed write to the word being read is merged lane by lane
    r_word = mem_q[r_idx];
    for (int i = 0; i < 4; i++)
      if (we && w_idx == r_idx && w_strb[i]) r_word[8*i+:8] = w_lane[8*i+:8];
    rvalid_d = mem_ren_i;
    rdata_d = !mem_ren_i ? rdata_q : r_fault ? 32'h0 : r_word;
    err_d = err_q;
    err_cause_d = err_cause_q;
    err_addr_d = err_addr_q;
    if ((w_fault || r_fault) && (!err_q || err_clr_i)) begin
      err_d = 1'b1;
      err_cause_d = w_fault ? w_cause : 2'b10;
      err_addr_d = w_fault ? mem_waddr_i : mem_raddr_i;
    end else if (err_clr_i) begin
      err_d = 1'b0;
      err_cause_d = 2'b00;
      err_addr_d = 32'h0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && w_strb[i]) mem_q[w_idx][8*i+:8] <= w_lane[8*i+:8];
    if (rst) begin
      rdata_q <= 32'h0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      err_cause_q <= 2'b00;
      err_addr_q <= 32'h0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      err_cause_q <= err_cause_d;
      err_addr_q <= err_addr_d;
    end
  end
  // a result already in flight when reset arrives is suppressed immediately
  assign mem_rvalid_o = rvalid_q & ~rst;
  assign mem_rdata_o = rdata_q;
  assign err_o = err_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o = err_addr_q;
endmodule
